// File: rtl/io_timer.sv
// io_timer: memory-mapped prescaled down-counter with auto-reload and level interrupt
module io_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic [2:0]            ctrl;
    logic [31:0]           load;
    logic [31:0]           count;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  done;
    logic                  ovf;
    logic [2:0]            sel;
    logic                  wr;
    logic                  wr_ctrl;
    logic                  wr_load;
    logic                  wr_pre;
    logic                  wr_stat;
    logic                  tick;
    logic                  expire;
    logic                  en_n;
    logic                  en_rise;
    logic                  unused;

    assign unused  = ^{addr[11:5], addr[1:0]};
    assign sel     = addr[4:2];
    assign wr      = cs && we;
    assign wr_ctrl = wr && sel == 3'd0;
    assign wr_load = wr && sel == 3'd1;
    assign wr_pre  = wr && sel == 3'd2;
    assign wr_stat = wr && sel == 3'd4;
    assign irq     = done && ctrl[2];

    // Tick qualification: a LOAD write or an EN-clearing CTRL write swallows the tick
    always_comb begin
        tick    = ctrl[0] && pcnt == prescale && !wr_load && !(wr_ctrl && !wdata[0]);
        expire  = tick && count <= 32'd1;
        en_rise = wr_ctrl && wdata[0] && !ctrl[0];
        en_n    = wr_ctrl ? wdata[0] : ctrl[0] && !(expire && !ctrl[1]);
    end

    // Register state; expiry sets DONE/OVF with priority over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            load     <= '0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ctrl     <= wr_ctrl ? wdata[2:0] : {ctrl[2:1], en_n};
            load     <= wr_load ? wdata : load;
            prescale <= wr_pre ? wdata[PRESCALE_W-1:0] : prescale;
            pcnt     <= (!en_n || wr_load || en_rise || pcnt == prescale) ? '0 : pcnt + PRESCALE_W'(1);
            count    <= wr_load ? wdata : expire ? (ctrl[1] ? load : 32'd0) : tick ? count - 32'd1 : count;
            done     <= expire || (done && !(wr_stat && wdata[0]));
            ovf      <= (expire && done) || (ovf && !(wr_stat && wdata[1]));
        end
    end

    // Combinational read mux, zero when not selected
    always_comb begin
        rdata = !cs           ? 32'd0 :
                sel == 3'd0   ? {29'd0, ctrl} :
                sel == 3'd1   ? load :
                sel == 3'd2   ? 32'(prescale) :
                sel == 3'd3   ? count :
                sel == 3'd4   ? {30'd0, ovf, done} : 32'd0;
    end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: scoreboard-driven checks of the io_timer register, count and interrupt behaviour
module tb_io_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];

    io_timer #(.PRESCALE_W(16)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic c, input logic w, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = c; we = w; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic look(input string n, input logic c, input logic [11:0] a, input logic [31:0] e);
        exp_q.push_back('{n, e});
        cs = c; we = 1'b0; addr = a;
        #1;
        obs_q.push_back(rdata);
        cs = 1'b0;
    endtask

    task automatic look_irq(input string n, input logic e);
        exp_q.push_back('{n, {31'd0, e}});
        obs_q.push_back({31'd0, irq});
    endtask

    task automatic do_reset();
        rst = 1'b1; cs = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] o;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            look($sformatf("reset_off%0d", i), 1'b1, 12'(i * 4), 32'd0);
        end
        look_irq("reset_irq", 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, o, e.v); end
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        logic [31:0] o;
        do_reset();
        bus(1, 1, 12'h004, 32'd5);
        bus(1, 1, 12'h000, 32'h5);
        look("os_count_start", 1'b1, 12'h00C, 32'd5);
        for (int k = 4; k >= 1; k--) begin
            @(negedge clk);
            look($sformatf("os_count_%0d", k), 1'b1, 12'h00C, 32'(k));
        end
        @(negedge clk);
        look("os_count_exp", 1'b1, 12'h00C, 32'd0);
        look("os_ctrl_exp", 1'b1, 12'h000, 32'h4);
        look("os_status_exp", 1'b1, 12'h010, 32'h1);
        look_irq("os_irq_exp", 1'b1);
        bus(1, 1, 12'h010, 32'h1);
        look_irq("os_irq_clr", 1'b0);
        look("os_status_clr", 1'b1, 12'h010, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, o, e.v); end
        end
    endtask

    task automatic test_auto_collision();
        exp_t e;
        logic [31:0] o;
        do_reset();
        bus(1, 1, 12'h008, 32'd3);
        bus(1, 1, 12'h004, 32'd2);
        bus(1, 1, 12'h000, 32'h3);
        look("au_count_n0", 1'b1, 12'h00C, 32'd2);
        repeat (3) @(negedge clk);
        look("au_count_n3", 1'b1, 12'h00C, 32'd2);
        @(negedge clk);
        look("au_count_n4", 1'b1, 12'h00C, 32'd1);
        repeat (3) @(negedge clk);
        look("au_status_n7", 1'b1, 12'h010, 32'h0);
        @(negedge clk);
        look("au_status_n8", 1'b1, 12'h010, 32'h1);
        look("au_reload_n8", 1'b1, 12'h00C, 32'd2);
        look_irq("au_irq_ie0", 1'b0);
        repeat (7) @(negedge clk);
        look("au_status_n15", 1'b1, 12'h010, 32'h1);
        @(negedge clk);
        look("au_ovf_n16", 1'b1, 12'h010, 32'h3);
        bus(1, 1, 12'h010, 32'h3);
        look("au_clr_n18", 1'b1, 12'h010, 32'h0);
        repeat (4) @(negedge clk);
        bus(1, 1, 12'h010, 32'h3);
        look("col_status_n24", 1'b1, 12'h010, 32'h1);
        look("col_count_n24", 1'b1, 12'h00C, 32'd2);
        repeat (2) @(negedge clk);
        bus(1, 1, 12'h004, 32'd9);
        look("col_load_n28", 1'b1, 12'h00C, 32'd9);
        repeat (4) @(negedge clk);
        look("col_tick_n32", 1'b1, 12'h00C, 32'd8);
        repeat (2) @(negedge clk);
        bus(1, 1, 12'h000, 32'h2);
        look("col_endis_n36", 1'b1, 12'h00C, 32'd8);
        look("col_ctrl_n36", 1'b1, 12'h000, 32'h2);
        repeat (8) @(negedge clk);
        look("col_hold", 1'b1, 12'h00C, 32'd8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, o, e.v); end
        end
    endtask

    task automatic test_bus();
        exp_t e;
        logic [31:0] o;
        do_reset();
        bus(0, 1, 12'h004, 32'hDEAD);
        bus(1, 0, 12'h004, 32'hBEEF);
        look("bus_noqual", 1'b1, 12'h004, 32'd0);
        bus(1, 1, 12'h00C, 32'd7);
        look("bus_count_ro", 1'b1, 12'h10C, 32'd0);
        bus(1, 1, 12'h014, 32'hFFFF_FFFF);
        bus(1, 1, 12'h018, 32'hFFFF_FFFF);
        bus(1, 1, 12'h01C, 32'hFFFF_FFFF);
        look("bus_off14", 1'b1, 12'h014, 32'd0);
        look("bus_off18", 1'b1, 12'h018, 32'd0);
        look("bus_off1c", 1'b1, 12'h01C, 32'd0);
        look("bus_status_ign", 1'b1, 12'h010, 32'd0);
        bus(1, 1, 12'h104, 32'h1234_5678);
        look("bus_alias_count", 1'b1, 12'h10C, 32'h1234_5678);
        look("bus_load", 1'b1, 12'h004, 32'h1234_5678);
        look("bus_cs0_read", 1'b0, 12'h004, 32'd0);
        bus(1, 1, 12'h008, 32'hFFFF_ABCD);
        look("bus_prescale", 1'b1, 12'h008, 32'h0000_ABCD);
        bus(1, 1, 12'h000, 32'hFFFF_FFF8);
        look("bus_ctrl_upper", 1'b1, 12'h000, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, o, e.v); end
        end
    endtask

    task automatic test_midreset();
        exp_t e;
        logic [31:0] o;
        do_reset();
        bus(1, 1, 12'h004, 32'd5);
        bus(1, 1, 12'h000, 32'h5);
        @(negedge clk);
        @(negedge clk);
        look("mr_count3", 1'b1, 12'h00C, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        look("mr_ctrl", 1'b1, 12'h000, 32'd0);
        look("mr_load", 1'b1, 12'h004, 32'd0);
        look("mr_count", 1'b1, 12'h00C, 32'd0);
        look_irq("mr_irq", 1'b0);
        repeat (10) @(negedge clk);
        look("mr_status_late", 1'b1, 12'h010, 32'd0);
        look("mr_count_late", 1'b1, 12'h00C, 32'd0);
        look_irq("mr_irq_late", 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, o, e.v); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_collision();
        test_bus();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped programmable down-counter timer peripheral hanging off the CPU-to-IO bus bridge, in one of the IO device slots (e.g. device 0, 0x0000-0x00ff).
- Consumes the bridge's chip select, write enable, 12-bit address and write data.
- Returns read data on a combinational path into the bridge's read mux.
- Raises a level interrupt on expiry.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and internal prescale counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- cs  input  1  chip select from bus bridge; access valid only when high.
- we  input  1  write enable from bus bridge; write occurs when cs&&we at the clock edge.
- addr  input  12  byte address within device; only addr[4:2] decoded, other bits ignored.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational.
- irq  output  1  interrupt, level, active-high.

Behaviour:
- Register map (addr[4:2]):
  - 0 CTRL rw: bit0 EN, bit1 AUTO (auto-reload), bit2 IE; upper bits read 0.
  - 1 LOAD rw 32b.
  - 2 PRESCALE rw, PRESCALE_W bits, zero-extended on read.
  - 3 COUNT ro.
  - 4 STATUS: bit0 DONE, bit1 OVF; write-1-to-clear per bit.
  - 5-7 read 0, writes ignored.
- Reset: CTRL=0, LOAD=0, PRESCALE=0, COUNT=0, prescale counter pcnt=0, DONE=0, OVF=0, irq=0.
- rdata:
  - cs=0 -> rdata=0.
  - cs=1 -> selected register, combinational.
  - A read in the same cycle as a write returns the pre-write value.
- Prescaler:
  - While EN=1, pcnt increments each cycle.
  - When pcnt==PRESCALE, a tick is generated that cycle and pcnt<=0.
  - PRESCALE=0 -> tick every cycle.
  - While EN=0, pcnt holds 0.
- Counting on tick with EN=1:
  - COUNT>1: COUNT<=COUNT-1.
  - COUNT<=1: expiry.
- Expiry:
  - DONE<=1.
  - OVF<=1 if DONE was already 1.
  - AUTO=1: COUNT<=LOAD, EN stays 1.
  - AUTO=0: COUNT<=0, EN<=0.
- Period: LOAD=N (N>=1) with PRESCALE=P gives expiry every N*(P+1) cycles in auto mode. LOAD=0 behaves as LOAD=1.
- Writes:
  - LOAD write: LOAD<=wdata, COUNT<=wdata, pcnt<=0. Any tick that cycle is discarded.
  - CTRL write: takes effect next edge. An EN 0->1 transition also clears pcnt.
  - COUNT write: ignored.
- Latency: after the edge that sets EN (PRESCALE=P), the first tick occurs P+1 cycles later. COUNT visibly decrements on that edge.
- irq = DONE && IE, from registered state (no combinational path from bus inputs). Stays high until DONE is cleared or IE is cleared.
- Simultaneous events:
  - STATUS clear-write in same cycle as expiry: the expiry set wins (DONE=1). OVF takes its set value if the old DONE was 1, otherwise the clear applies.
  - CTRL write clearing EN in same cycle as a tick: the tick is discarded, no expiry.
- Reset mid-count returns all state to reset values in one cycle; no pending expiry is retained.

Test Plan:
- Reset defaults: assert rst 2 cycles, read all offsets -> rdata=0 everywhere, irq=0.
- One-shot, PRESCALE=0:
  - Write LOAD=5, CTRL=0x5 (EN|IE) -> COUNT reads 4,3,2,1 on successive cycles.
  - On the 5th tick DONE=1, irq=1, COUNT=0, CTRL.EN=0.
  - Write STATUS=1 -> irq=0 next cycle.
- Auto-reload with prescale:
  - PRESCALE=3, LOAD=2, CTRL=0x3 -> expiry every 8 cycles.
  - Leave DONE uncleared through the second expiry -> OVF=1.
- Collision:
  - Time a STATUS=1 write to coincide with expiry -> DONE remains 1 after the edge.
  - Time a LOAD=9 write to coincide with a tick -> COUNT=9, no decrement that cycle.
- Bus qualifiers:
  - Writes with cs=0 or we=0 -> no register change.
  - Writes to COUNT and to offsets 0x14-0x1C -> ignored.
  - addr=0x10C aliases COUNT (high bits ignored).
- Reset mid-operation: assert rst while COUNT=3, EN=1 -> next cycle all registers 0, irq=0, no expiry afterward.
